// File: rtl/rom_16bit_pkg.sv
// Shared constants and the content function for the 16-bit page ROM.
package rom_16bit_pkg;

    localparam int unsigned ROM_DATA_WIDTH = 16;
    localparam int unsigned ROM_ADDR_WIDTH = 8;
    localparam logic [7:0]  ROM_PATTERN    = 8'h5A;

    // Content word for a given address: {addr ^ pattern, addr}.
    function automatic logic [ROM_DATA_WIDTH-1:0] rom_word(input logic [ROM_ADDR_WIDTH-1:0] addr);
        return {addr[7:0] ^ ROM_PATTERN, addr[7:0]};
    endfunction

endpackage

// File: rtl/rom_16bit_sync_if.sv
// Read bus for rom_16bit_sync. ROM_16BIT_PARITY_EN adds the data_par signal.
interface rom_16bit_sync_if
    import rom_16bit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH
);
    logic                  ce;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  addr_err;
`ifdef ROM_16BIT_PARITY_EN
    logic                  data_par;

    modport master (output ce, read_en, address, input data, data_valid, addr_err, data_par);
    modport slave  (input ce, read_en, address, output data, data_valid, addr_err, data_par);
`else
    modport master (output ce, read_en, address, input data, data_valid, addr_err);
    modport slave  (input ce, read_en, address, output data, data_valid, addr_err);
`endif

endinterface

// File: rtl/rom_16bit_array.sv
// Combinational DEPTH x DATA_WIDTH content lookup with in-range detect.
module rom_16bit_array
    import rom_16bit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 256
) (
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] word_c,
    output logic                  in_range_c
);

    logic [DATA_WIDTH-1:0] table_c [DEPTH];

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
        assign table_c[i] = DATA_WIDTH'(rom_word(ROM_ADDR_WIDTH'(i)));
    end

    // Out-of-range addresses read as zero so the top can load word_c directly.
    always_comb begin
        in_range_c = (32'(address) < DEPTH);
        word_c     = '0;
        if (in_range_c) begin
            word_c = table_c[address];
        end
    end

endmodule

// File: rtl/rom_16bit_sync.sv
// Synchronous 16-bit page ROM: registered data, valid and range-error strobes.
// Optional registered even-parity output under ROM_16BIT_PARITY_EN.
module rom_16bit_sync
    import rom_16bit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    rom_16bit_sync_if.slave  bus
);

    logic [DATA_WIDTH-1:0] word_c;
    logic                  in_range_c;
    logic                  rd_c;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  err_q;

    rom_16bit_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .address    (bus.address),
        .word_c     (word_c),
        .in_range_c (in_range_c)
    );

    assign rd_c = bus.ce && bus.read_en;

    // Data holds between reads; strobes are single-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (rd_c) begin
            data_q  <= word_c;
            valid_q <= 1'b1;
            err_q   <= !in_range_c;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.addr_err   = err_q;

`ifdef ROM_16BIT_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (rd_c) begin
            par_q <= ^word_c;
        end
    end

    assign bus.data_par = par_q;
`endif

endmodule

// File: tb/tb_rom_16bit_sync.sv
// Self-checking bench for rom_16bit_sync: full-depth and DEPTH=200 instances.
module tb_rom_16bit_sync;
    import rom_16bit_pkg::*;

    typedef struct {
        logic [15:0] data;
        logic        valid;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [15:0] hold_a;
    logic [15:0] hold_b;

    rom_16bit_sync_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus_a ();
    rom_16bit_sync_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus_b ();

    rom_16bit_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    rom_16bit_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(200)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input bit sel, input logic c, input logic r, input logic [7:0] a);
        if (sel) begin
            bus_b.ce = c; bus_b.read_en = r; bus_b.address = a;
            bus_a.ce = 1'b0; bus_a.read_en = 1'b0;
        end else begin
            bus_a.ce = c; bus_a.read_en = r; bus_a.address = a;
            bus_b.ce = 1'b0; bus_b.read_en = 1'b0;
        end
    endtask

    task automatic check_out(input bit sel, input string tag);
        exp_t e;
        logic [15:0] od;
        logic        ov;
        logic        oe;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e  = exp_q.pop_front();
        od = sel ? bus_b.data : bus_a.data;
        ov = sel ? bus_b.data_valid : bus_a.data_valid;
        oe = sel ? bus_b.addr_err : bus_a.addr_err;
        chk({tag, "_data"},  32'(od), 32'(e.data));
        chk({tag, "_valid"}, 32'(ov), 32'(e.valid));
        chk({tag, "_err"},   32'(oe), 32'(e.err));
`ifdef ROM_16BIT_PARITY_EN
        chk({tag, "_par"}, 32'(sel ? bus_b.data_par : bus_a.data_par), 32'(^e.data));
`endif
    endtask

    // One clock of stimulus: the expected result is queued, then checked after the edge.
    task automatic step(input bit sel, input logic c, input logic r, input logic [7:0] a,
                        input string tag);
        exp_t e;
        int unsigned depth;
        depth = sel ? 200 : 256;
        drive(sel, c, r, a);
        e.data  = sel ? hold_b : hold_a;
        e.valid = 1'b0;
        e.err   = 1'b0;
        if (c && r) begin
            e.valid = 1'b1;
            if (32'(a) < depth) begin
                e.data = rom_word(a);
            end else begin
                e.data = 16'h0000;
                e.err  = 1'b1;
            end
        end
        if (sel) hold_b = e.data; else hold_a = e.data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(sel, tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hold_a = 16'h0000;
        hold_b = 16'h0000;
        rst_n  = 1'b0;
        bus_a.ce = 1'b0; bus_a.read_en = 1'b0; bus_a.address = 8'h00;
        bus_b.ce = 1'b0; bus_b.read_en = 1'b0; bus_b.address = 8'h00;

        #12;
        chk("rst_data",  32'(bus_a.data), 32'h0);
        chk("rst_valid", 32'(bus_a.data_valid), 32'h0);
        chk("rst_err",   32'(bus_b.addr_err), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single reads, each followed by an idle cycle to confirm a one-cycle strobe.
        step(1'b0, 1'b1, 1'b1, 8'd0, "rd0");
        chk("rd0_const", 32'(bus_a.data), 32'h5A00);
        step(1'b0, 1'b0, 1'b0, 8'd0, "idle0");
        step(1'b0, 1'b1, 1'b1, 8'd3, "rd3");
        chk("rd3_const", 32'(bus_a.data), 32'h5903);
        step(1'b0, 1'b0, 1'b0, 8'd3, "idle3");
        step(1'b0, 1'b1, 1'b1, 8'd255, "rd255");
        chk("rd255_const", 32'(bus_a.data), 32'hA5FF);
        step(1'b0, 1'b0, 1'b0, 8'd0, "idle255");

        // Reset asserted mid-read takes effect immediately and holds until release.
        drive(1'b0, 1'b1, 1'b1, 8'd4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data",  32'(bus_a.data), 32'h0);
        chk("arst_valid", 32'(bus_a.data_valid), 32'h0);
        chk("arst_err",   32'(bus_a.addr_err), 32'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_data",  32'(bus_a.data), 32'h0);
        chk("arst_hold_valid", 32'(bus_a.data_valid), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        hold_a = 16'h0000;
        hold_b = 16'h0000;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Page sweep, one word per cycle.
        for (int a = 0; a < 256; a++) begin
            step(1'b0, 1'b1, 1'b1, 8'(a), "sweep");
        end

        // Gating: ce low, then read_en low, both hold data and drop valid.
        step(1'b0, 1'b1, 1'b1, 8'd5, "gate_rd5");
        chk("gate_rd5_const", 32'(bus_a.data), 32'h5F05);
        step(1'b0, 1'b0, 1'b1, 8'd9, "gate_ce0");
        chk("gate_ce0_const", 32'(bus_a.data), 32'h5F05);
        step(1'b0, 1'b1, 1'b0, 8'd9, "gate_re0");
        chk("gate_re0_const", 32'(bus_a.data), 32'h5F05);

        // Out of range on the DEPTH=200 instance.
        step(1'b1, 1'b1, 1'b1, 8'd10, "b_rd10");
        step(1'b1, 1'b1, 1'b1, 8'd200, "b_oor200");
        chk("b_oor200_err_const", 32'(bus_b.addr_err), 32'h1);
        step(1'b1, 1'b1, 1'b1, 8'd199, "b_rd199");
        chk("b_rd199_const", 32'(bus_b.data), 32'h9DC7);
        step(1'b1, 1'b1, 1'b1, 8'd250, "b_oor250");
        step(1'b1, 1'b0, 1'b0, 8'd0, "b_idle");

        // Parity-sensitive addresses (checked inside check_out when enabled).
        step(1'b0, 1'b1, 1'b1, 8'd1, "par1");
        step(1'b0, 1'b1, 1'b1, 8'd2, "par2");
        step(1'b0, 1'b1, 1'b1, 8'd4, "par4");
        step(1'b0, 1'b0, 1'b0, 8'd0, "par_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
